// File: rtl/cobalt_pkg.sv
// Shared widths and the issue-queue entry record for the multiplier issue queue.
// The entry record is sized by the package defaults, so DATA_W/TAG_W on the top stay at these values.
package cobalt_pkg;

    localparam int CB_DATA_W = 32;
    localparam int CB_TAG_W  = 6;

    typedef struct packed {
        logic                 rs_valid;
        logic [CB_TAG_W-1:0]  rs_tag;
        logic [CB_DATA_W-1:0] rs_data;
        logic                 rt_valid;
        logic [CB_TAG_W-1:0]  rt_tag;
        logic [CB_DATA_W-1:0] rt_data;
        logic [CB_TAG_W-1:0]  rd_tag;
    } iq_entry_t;

    function automatic logic operands_ready(input iq_entry_t e);
        return e.rs_valid && e.rt_valid;
    endfunction

    // Snoop one broadcast: only operands still waiting on that tag pick up the value.
    function automatic iq_entry_t wake(input iq_entry_t e, input logic v,
                                       input logic [CB_TAG_W-1:0] tag,
                                       input logic [CB_DATA_W-1:0] data);
        iq_entry_t r;
        r = e;
        if (v && !r.rs_valid && r.rs_tag == tag) begin
            r.rs_valid = 1'b1;
            r.rs_data  = data;
        end
        if (v && !r.rt_valid && r.rt_tag == tag) begin
            r.rt_valid = 1'b1;
            r.rt_data  = data;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_pipe.sv
// Multiplier pipeline: operand stage 0 followed by LAT product stages with valid/tag per stage.
// A single stall freezes every stage; squash clears all valids.
module mult_pipe
    import cobalt_pkg::*;
#(
    parameter int DATA_W = CB_DATA_W,
    parameter int TAG_W  = CB_TAG_W,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              squash,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    logic [LAT:0]      vld;
    logic [TAG_W-1:0]  tag  [LAT+1];
    logic [DATA_W-1:0] prod [LAT];
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] prod_lo;

    // Low half of the signed product; the truncating context keeps only DATA_W bits.
    assign prod_lo = $signed(op_a) * $signed(op_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld  <= '0;
            op_a <= '0;
            op_b <= '0;
            for (int i = 0; i <= LAT; i++) tag[i] <= '0;
            for (int i = 0; i < LAT; i++) prod[i] <= '0;
        end else if (squash) begin
            vld <= '0;
        end else if (!stall) begin
            vld    <= {vld[LAT-1:0], in_valid};
            op_a   <= in_a;
            op_b   <= in_b;
            tag[0] <= in_tag;
            for (int i = 1; i <= LAT; i++) tag[i] <= tag[i-1];
            prod[0] <= prod_lo;
            for (int i = 1; i < LAT; i++) prod[i] <= prod[i-1];
        end
    end

    assign out_valid = vld[LAT];
    assign out_data  = prod[LAT-1];
    assign out_tag   = tag[LAT];

endmodule

// File: rtl/issue_queue_mult.sv
// Age-ordered issue queue with CDB wakeup feeding a pipelined multiplier with a held CDB result.
// Optional squash port enabled by defining IQMULT_FLUSH_EN.
module issue_queue_mult
    import cobalt_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = CB_DATA_W,
    parameter int TAG_W    = CB_TAG_W,
    parameter int MULT_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IQMULT_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              dispatch_en,
    output logic              dispatch_ready,
    input  logic [DATA_W-1:0] dispatch_rs_data,
    input  logic [DATA_W-1:0] dispatch_rt_data,
    input  logic [TAG_W-1:0]  dispatch_rs_tag,
    input  logic [TAG_W-1:0]  dispatch_rt_tag,
    input  logic              dispatch_rs_valid,
    input  logic              dispatch_rt_valid,
    input  logic [TAG_W-1:0]  dispatch_rd_tag,
    input  logic              cdb_in_valid,
    input  logic [TAG_W-1:0]  cdb_in_tag,
    input  logic [DATA_W-1:0] cdb_in_data,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  cdb_tag
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    iq_entry_t     q     [DEPTH];
    iq_entry_t     woke  [DEPTH];
    iq_entry_t     q_nxt [DEPTH];
    iq_entry_t     raw_entry, new_entry;
    logic [CW-1:0] count, count_nxt;
    logic [IW-1:0] sel;
    logic          found, issue, do_dispatch, stall, squash;

`ifdef IQMULT_FLUSH_EN
    assign squash = flush;
`else
    assign squash = 1'b0;
`endif

    assign dispatch_ready = count < CW'(DEPTH);
    assign do_dispatch    = dispatch_en && dispatch_ready;
    assign stall          = cdb_req && !cdb_grant;
    assign issue          = found && !stall;

    assign raw_entry = '{rs_valid: dispatch_rs_valid, rs_tag: dispatch_rs_tag,
                         rs_data: dispatch_rs_data, rt_valid: dispatch_rt_valid,
                         rt_tag: dispatch_rt_tag, rt_data: dispatch_rt_data,
                         rd_tag: dispatch_rd_tag};
    // Same-cycle broadcast bypasses straight into the dispatching entry.
    assign new_entry = wake(raw_entry, cdb_in_valid, cdb_in_tag, cdb_in_data);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count && operands_ready(q[i])) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) woke[i] = wake(q[i], cdb_in_valid, cdb_in_tag, cdb_in_data);
        for (int i = 0; i < DEPTH; i++) q_nxt[i] = woke[i];
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue && i >= int'(sel)) q_nxt[i] = woke[i+1];
        end
        count_nxt = count - CW'(issue);
        // Youngest slot is computed after the issue shift so dispatch+issue keeps the count.
        for (int i = 0; i < DEPTH; i++) begin
            if (do_dispatch && CW'(i) == count_nxt) q_nxt[i] = new_entry;
        end
        count_nxt = count_nxt + CW'(do_dispatch);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else if (squash) begin
            count <= '0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
        end
    end

    mult_pipe #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .LAT    (MULT_LAT)
    ) u_mult_pipe (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .squash    (squash),
        .in_valid  (issue),
        .in_a      (q[sel].rs_data),
        .in_b      (q[sel].rt_data),
        .in_tag    (q[sel].rd_tag),
        .out_valid (cdb_req),
        .out_data  (cdb_data),
        .out_tag   (cdb_tag)
    );

endmodule

// File: tb/tb_issue_queue_mult.sv
// Self-checking bench for issue_queue_mult: vector table, directed corner sequences, random run vs model.
module tb_issue_queue_mult;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam int LAT   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush;
    logic          dispatch_en, dispatch_ready;
    logic [DW-1:0] dispatch_rs_data, dispatch_rt_data;
    logic [TW-1:0] dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag;
    logic          dispatch_rs_valid, dispatch_rt_valid;
    logic          cdb_in_valid;
    logic [TW-1:0] cdb_in_tag;
    logic [DW-1:0] cdb_in_data;
    logic          cdb_req, cdb_grant;
    logic [DW-1:0] cdb_data;
    logic [TW-1:0] cdb_tag;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    issue_queue_mult #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .MULT_LAT(LAT)) dut (
        .clk               (clk),
        .rst               (rst),
`ifdef IQMULT_FLUSH_EN
        .flush             (flush),
`endif
        .dispatch_en       (dispatch_en),
        .dispatch_ready    (dispatch_ready),
        .dispatch_rs_data  (dispatch_rs_data),
        .dispatch_rt_data  (dispatch_rt_data),
        .dispatch_rs_tag   (dispatch_rs_tag),
        .dispatch_rt_tag   (dispatch_rt_tag),
        .dispatch_rs_valid (dispatch_rs_valid),
        .dispatch_rt_valid (dispatch_rt_valid),
        .dispatch_rd_tag   (dispatch_rd_tag),
        .cdb_in_valid      (cdb_in_valid),
        .cdb_in_tag        (cdb_in_tag),
        .cdb_in_data       (cdb_in_data),
        .cdb_req           (cdb_req),
        .cdb_grant         (cdb_grant),
        .cdb_data          (cdb_data),
        .cdb_tag           (cdb_tag)
    );

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0]  rd;
        logic        rs_v;
        logic [5:0]  rs_t;
        logic [31:0] rs_d;
        logic        rt_v;
        logic [5:0]  rt_t;
        logic [31:0] rt_d;
    } minst_t;

    vec_t   tbl [7];
    minst_t pend [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        dispatch_en = 1'b0;
        dispatch_rs_data = '0; dispatch_rt_data = '0;
        dispatch_rs_tag = '0; dispatch_rt_tag = '0; dispatch_rd_tag = '0;
        dispatch_rs_valid = 1'b0; dispatch_rt_valid = 1'b0;
        cdb_in_valid = 1'b0; cdb_in_tag = '0; cdb_in_data = '0;
        cdb_grant = 1'b1;
    endtask

    task automatic dispatch(input logic [5:0] rd, input logic rsv, input logic [5:0] rst_g,
                            input logic [31:0] rsd, input logic rtv, input logic [5:0] rtt,
                            input logic [31:0] rtd);
        dispatch_en = 1'b1;
        dispatch_rd_tag = rd;
        dispatch_rs_valid = rsv; dispatch_rs_tag = rst_g; dispatch_rs_data = rsd;
        dispatch_rt_valid = rtv; dispatch_rt_tag = rtt; dispatch_rt_data = rtd;
        tick();
        dispatch_en = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!cdb_req && n < 30) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] mprod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    function automatic void mwake(input logic [5:0] t, input logic [31:0] d);
        foreach (pend[i]) begin
            if (!pend[i].rs_v && pend[i].rs_t == t) begin pend[i].rs_v = 1'b1; pend[i].rs_d = d; end
            if (!pend[i].rt_v && pend[i].rt_t == t) begin pend[i].rt_v = 1'b1; pend[i].rt_d = d; end
        end
    endfunction

    initial begin
        int n, got, idx, rd_next;
        logic s_req, s_ready, hold;
        logic [31:0] s_data, h_data;
        logic [5:0] s_tag, h_tag;
        minst_t m;

        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_ready", dispatch_ready, 1);
        check("rst_req", cdb_req, 0);
        check("rst_data", cdb_data, 0);
        check("rst_tag", cdb_tag, 0);

        tbl[0] = '{32'd3,        32'hFFFFFFFB, 6'h12, 32'hFFFFFFF1};
        tbl[1] = '{32'h7FFFFFFF, 32'd2,        6'h01, 32'hFFFFFFFE};
        tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 6'h02, 32'h00000001};
        tbl[3] = '{32'h80000000, 32'hFFFFFFFF, 6'h03, 32'h80000000};
        tbl[4] = '{32'h00010000, 32'h00010000, 6'h04, 32'h00000000};
        tbl[5] = '{32'd12345,    32'hFFFFFFFE, 6'h05, 32'hFFFF9F8E};
        tbl[6] = '{32'd0,        32'h12345678, 6'h3F, 32'h00000000};
        foreach (tbl[i]) begin
            dispatch(tbl[i].rd, 1'b1, 6'h00, tbl[i].rs, 1'b1, 6'h00, tbl[i].rt);
            wait_req(n);
            check("vec_latency", n, LAT + 1);
            check("vec_data", cdb_data, tbl[i].exp);
            check("vec_tag", cdb_tag, tbl[i].rd);
            tick();
        end

        // Full queue blocked on one tag, then a single broadcast releases all in age order.
        for (int i = 0; i < DEPTH; i++) dispatch(6'(1 + i), 1'b0, 6'h07, 32'd0, 1'b1, 6'h00, 32'(i + 1));
        check("full_ready", dispatch_ready, 0);
        cdb_in_valid = 1'b1; cdb_in_tag = 6'h07; cdb_in_data = 32'd9;
        tick();
        cdb_in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 40 && got < DEPTH; c++) begin
            if (cdb_req) begin
                check("wake_tag", cdb_tag, 6'(1 + got));
                check("wake_data", cdb_data, 32'(9 * (got + 1)));
                got++;
            end
            tick();
        end
        check("wake_count", got, DEPTH);
        check("ready_back", dispatch_ready, 1);

        // Same-cycle bypass.
        cdb_in_valid = 1'b1; cdb_in_tag = 6'h05; cdb_in_data = 32'd2;
        dispatch(6'h33, 1'b0, 6'h05, 32'd0, 1'b1, 6'h00, 32'd7);
        cdb_in_valid = 1'b0;
        wait_req(n);
        check("bypass_latency", n, LAT + 1);
        check("bypass_data", cdb_data, 32'd14);
        check("bypass_tag", cdb_tag, 6'h33);
        tick();

        // Grant withheld: result holds, then three back-to-back results.
        cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) dispatch(6'(8'h11 + i), 1'b1, 6'h00, 32'(i + 2), 1'b1, 6'h00, 32'd3);
        wait_req(n);
        check("stall_req", cdb_req, 1);
        for (int c = 0; c < 10; c++) begin
            check("stall_hold_req", cdb_req, 1);
            check("stall_hold_tag", cdb_tag, 6'h11);
            check("stall_hold_data", cdb_data, 32'd6);
            tick();
        end
        cdb_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("b2b_req", cdb_req, 1);
            check("b2b_tag", cdb_tag, 6'(8'h11 + k));
            check("b2b_data", cdb_data, 32'((k + 2) * 3));
            tick();
        end
        check("b2b_done", cdb_req, 0);

        // Asynchronous reset mid-operation with a held result and a full queue.
        cdb_grant = 1'b0;
        dispatch(6'h15, 1'b1, 6'h00, 32'd4, 1'b1, 6'h00, 32'd5);
        wait_req(n);
        for (int i = 0; i < DEPTH; i++) dispatch(6'(8'h31 + i), 1'b0, 6'h3F, 32'd0, 1'b1, 6'h00, 32'd1);
        check("pre_rst_ready", dispatch_ready, 0);
        check("pre_rst_req", cdb_req, 1);
        rst = 1'b0;
        #1;
        check("async_rst_req", cdb_req, 0);
        check("async_rst_ready", dispatch_ready, 1);
        check("async_rst_data", cdb_data, 0);
        check("async_rst_tag", cdb_tag, 0);
        tick();
        rst = 1'b1;
        cdb_grant = 1'b1;
        cdb_in_valid = 1'b1; cdb_in_tag = 6'h3F; cdb_in_data = 32'd1;
        tick();
        cdb_in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            if (cdb_req) got++;
            tick();
        end
        check("post_rst_empty", got, 0);

`ifdef IQMULT_FLUSH_EN
        dispatch(6'h16, 1'b1, 6'h00, 32'd3, 1'b1, 6'h00, 32'd3);
        for (int i = 0; i < DEPTH - 1; i++) dispatch(6'(8'h35 + i), 1'b0, 6'h3E, 32'd0, 1'b1, 6'h00, 32'd1);
        flush = 1'b1;
        dispatch(6'h17, 1'b1, 6'h00, 32'd2, 1'b1, 6'h00, 32'd2);
        flush = 1'b0;
        check("flush_req", cdb_req, 0);
        for (int i = 0; i < DEPTH - 1; i++) dispatch(6'(8'h38 + i), 1'b0, 6'h3D, 32'd0, 1'b1, 6'h00, 32'd1);
        check("flush_empty_ready", dispatch_ready, 1);
        got = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            if (cdb_req) got++;
            tick();
        end
        check("flush_no_result", got, 0);
        cdb_in_valid = 1'b1; cdb_in_tag = 6'h3D; cdb_in_data = 32'd1;
        tick();
        cdb_in_valid = 1'b0;
        repeat (20) tick();
`endif

        // Random traffic against the model.
        idle();
        rd_next = 0;
        hold = 1'b0;
        h_data = '0;
        h_tag = '0;
        for (int c = 0; c < 700; c++) begin
            if (c < 600) begin
                dispatch_en = ($urandom_range(0, 99) < 60);
                cdb_in_valid = ($urandom_range(0, 99) < 30);
                cdb_in_tag = 6'h20 + 6'($urandom_range(0, 7));
                cdb_grant = ($urandom_range(0, 99) < 70);
            end else begin
                dispatch_en = 1'b0;
                cdb_in_valid = (c < 608);
                cdb_in_tag = 6'h20 + 6'((c - 600) % 8);
                cdb_grant = 1'b1;
            end
            cdb_in_data = $urandom;
            dispatch_rd_tag = 6'(rd_next);
            dispatch_rs_valid = $urandom_range(0, 1);
            dispatch_rs_tag = 6'h20 + 6'($urandom_range(0, 7));
            dispatch_rs_data = $urandom;
            dispatch_rt_valid = $urandom_range(0, 1);
            dispatch_rt_tag = 6'h20 + 6'($urandom_range(0, 7));
            dispatch_rt_data = $urandom;

            @(negedge clk);
            s_req = cdb_req; s_data = cdb_data; s_tag = cdb_tag; s_ready = dispatch_ready;
            if (hold) begin
                check("rand_hold_req", s_req, 1);
                check("rand_hold_data", s_data, h_data);
                check("rand_hold_tag", s_tag, h_tag);
            end
            hold = s_req && !cdb_grant;
            h_data = s_data;
            h_tag = s_tag;
            if (s_req && cdb_grant) begin
                idx = -1;
                foreach (pend[i]) if (pend[i].rd == s_tag) idx = i;
                check("rand_tag_known", idx >= 0, 1);
                if (idx >= 0) begin
                    check("rand_data", s_data, mprod(pend[idx].rs_d, pend[idx].rt_d));
                    pend.delete(idx);
                end
            end
            if (dispatch_en && s_ready) begin
                m.rd = dispatch_rd_tag;
                m.rs_v = dispatch_rs_valid; m.rs_t = dispatch_rs_tag; m.rs_d = dispatch_rs_data;
                m.rt_v = dispatch_rt_valid; m.rt_t = dispatch_rt_tag; m.rt_d = dispatch_rt_data;
                pend.push_back(m);
                rd_next = (rd_next + 1) % 32;
            end
            if (cdb_in_valid) mwake(cdb_in_tag, cdb_in_data);
            @(posedge clk);
            #1;
        end
        check("rand_drained", pend.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/issue_queue_mult.md
ISSUE_QUEUE_MULT -- requirements
Module: issue_queue_mult

Interface
REQ-001 Parameter DEPTH, default 4, queue entry count (2..16).
REQ-002 Parameter DATA_W, default 32, operand/result width.
REQ-003 Parameter TAG_W, default 6, rename tag width.
REQ-004 Parameter MULT_LAT, default 4, multiplier pipeline stages (1..8).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 dispatch_en  in  1  dispatch request.
REQ-008 dispatch_ready  out  1  queue can accept.
REQ-009 dispatch_rs_data/dispatch_rt_data  in  DATA_W  operand values.
REQ-010 dispatch_rs_tag/dispatch_rt_tag  in  TAG_W  producer tags.
REQ-011 dispatch_rs_valid/dispatch_rt_valid  in  1  operand already valid.
REQ-012 dispatch_rd_tag  in  TAG_W  destination tag.
REQ-013 cdb_in_valid/cdb_in_tag/cdb_in_data  in  1/TAG_W/DATA_W  snooped broadcast.
REQ-014 cdb_req  out  1  result pending; cdb_grant  in  1  arbiter accepts.
REQ-015 cdb_data/cdb_tag  out  DATA_W/TAG_W  result and its tag.
REQ-016 flush  in  1  squash all (present only with IQMULT_FLUSH_EN).

Function
REQ-017 dispatch_ready SHALL be 1 when occupied entries < DEPTH, computed from registered count only (no same-cycle issue lookahead).
REQ-018 Dispatch SHALL occur on dispatch_en && dispatch_ready; entry written at youngest position next edge.
REQ-019 Entries SHALL be kept in age order; issued entry removed and younger entries shift toward oldest slot in the same edge.
REQ-020 Wakeup: cdb_in_valid with tag equal to a non-valid operand's tag SHALL set that operand valid and capture cdb_in_data next edge.
REQ-021 A dispatching operand whose tag matches a same-cycle cdb_in broadcast SHALL be written valid with cdb_in_data (bypass).
REQ-022 Issue SHALL select the oldest entry with both operands valid, only when pipeline stage 0 advances; at most one issue per cycle.
REQ-023 Product SHALL be low DATA_W bits of signed rs*rt.
REQ-024 Result of instruction issued at edge N SHALL present cdb_req=1 with cdb_data/cdb_tag after edge N+MULT_LAT absent stalls.
REQ-025 cdb_req/cdb_data/cdb_tag SHALL hold stable until cdb_grant=1; whole pipeline stalls while final stage valid and not granted.
REQ-026 Grant and new result arriving same edge SHALL present the new result next cycle with no bubble.
REQ-027 Dispatch and issue same edge SHALL both occur; count unchanged.

Reset
REQ-028 On rst=0: all entries and pipeline stages invalid, count=0, cdb_req=0, cdb_data=0, cdb_tag=0, dispatch_ready=1 after release; applies immediately mid-operation.

Configuration
REQ-029 Macro IQMULT_FLUSH_EN defined: flush=1 SHALL invalidate all entries and pipeline stages at next edge, overriding same-cycle dispatch, wakeup and issue; cdb_req=0 next cycle.
REQ-030 Macro undefined: flush port absent; no squash path.

Structure
REQ-031 Default DATA_W, TAG_W constants and entry record layout SHALL live in shared package cobalt_pkg.
REQ-032 Sub-module mult_pipe SHALL hold the MULT_LAT-stage multiplier with valid/tag per stage and global stall.

Verification
REQ-033 Dispatch rs=3,rt=-5 both valid, tag 0x12, grant tied 1 -> cdb_req with data 0xFFFFFFF1, tag 0x12 exactly MULT_LAT cycles after issue.
REQ-034 Dispatch DEPTH entries with rs tag 0x07 unresolved -> dispatch_ready=0; CDB tag 0x07 data 9 -> all issue oldest-first, ready returns 1.
REQ-035 Dispatch with rs tag 0x05 while cdb_in tag 0x05 data 2 same cycle -> operand captured, issues next cycle.
REQ-036 Grant held 0 for 10 cycles with 3 ready entries -> cdb outputs stable, no loss; grant 1 -> three results back-to-back in age order.
REQ-037 Assert rst low mid-pipeline -> cdb_req=0 immediately, count=0; with IQMULT_FLUSH_EN, flush with dispatch same cycle -> queue empty next cycle.
